// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the I/D cache memory-port arbiter.
// Burst length follows the cache line geometry.
package mem_arb_pkg;

  localparam int CACHE_B         = 4;
  localparam int ARB_BURST_WORDS = 1 << (CACHE_B - 2);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_gnt_t;

  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I and D caches.
// A grant is held for a full line burst or until the owner drops req.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_WORDS = ARB_BURST_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wen,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  input  logic                  d_req,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic                  d_wen,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  m_req,
  output logic [DATA_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wen,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ready,
  output logic                  stall
);

  localparam int            CW   = cnt_w(BURST_WORDS);
  localparam logic [CW-1:0] LAST = CW'(BURST_WORDS - 1);

  arb_state_t    state_q, state_d;
  arb_gnt_t      last_q, last_d;
  logic [CW-1:0] beat_q, beat_d;

  // In a BUSY state m_req mirrors the owner's req, so it doubles as
  // the abandon detector.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        unique case (1'b1)
          i_req & d_req:
            state_d = (last_q == GNT_I) ? ARB_BUSY_D : ARB_BUSY_I;
          i_req & ~d_req: state_d = ARB_BUSY_I;
          d_req & ~i_req: state_d = ARB_BUSY_D;
          default:        state_d = ARB_IDLE;
        endcase
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (!m_req || (m_ready && beat_q == LAST)) begin
          state_d = ARB_IDLE;
          last_d  = (state_q == ARB_BUSY_I) ? GNT_I : GNT_D;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    beat_d = beat_q;
    if (state_q == ARB_IDLE) begin
      beat_d = '0;
    end else if (m_req && m_ready) begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_comb begin
    m_req   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wen   = 1'b0;
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    i_rdata = '0;
    d_rdata = '0;
    unique case (state_q)
      ARB_BUSY_I: begin
        m_req   = i_req;
        m_addr  = i_addr;
        m_wdata = i_wdata;
        m_wen   = i_wen & i_req;
        i_ack   = m_ready & i_req;
        i_rdata = m_rdata;
      end
      ARB_BUSY_D: begin
        m_req   = d_req;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_wen   = d_wen & d_req;
        d_ack   = m_ready & d_req;
        d_rdata = m_rdata;
      end
      default: ;
    endcase
  end

  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      last_q  <= GNT_I;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

endmodule
